// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers: NOP encoding,
// occupancy state encoding and default bundle widths per stage boundary.
package pipe_pkg;

   localparam logic [3:0]  OPCODE_NOP = 4'hF;
   localparam logic [15:0] NOP_INSN   = {OPCODE_NOP, 12'h000};

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } stage_state_e;

   localparam int unsigned IF_ID_CTRL_W  = 4;
   localparam int unsigned IF_ID_DATA_W  = 48;
   localparam int unsigned ID_EX_CTRL_W  = 12;
   localparam int unsigned ID_EX_DATA_W  = 48;
   localparam int unsigned EX_MEM_CTRL_W = 8;
   localparam int unsigned EX_MEM_DATA_W = 48;
   localparam int unsigned MEM_WB_CTRL_W = 4;
   localparam int unsigned MEM_WB_DATA_W = 48;

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer,
// synchronous flush, NOP bubble when empty and a saturating stall counter.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned       CTRL_W   = 12,
   parameter int unsigned       DATA_W   = 48,
   parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_INSN),
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              clr_cnt
);

   stage_state_e      state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              in_fire, out_fire;

   // Handshake outputs decode registered state only.
   always_comb begin
      in_ready  = (state_q != StTwo);
      out_valid = (state_q != StEmpty);
      occupancy = state_q;
      stall_cnt = stall_q;
      in_fire   = in_valid & in_ready;
      out_fire  = out_valid & out_ready;
      out_ctrl  = out_valid ? main_ctrl_q : '0;
      out_data  = out_valid ? main_data_q : NOP_DATA;
   end

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  state_d     = StOne;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
            end
            StOne: begin
               if (in_fire && out_fire) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (in_fire) begin
                  state_d     = StTwo;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (out_fire) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (out_fire) begin
                  state_d     = StOne;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   // Flush deliberately leaves the counter alone; only clr_cnt or reset zero it.
   always_comb begin
      stall_d = stall_q;
      if (clr_cnt) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StEmpty;
         main_ctrl_q <= '0;
         main_data_q <= NOP_DATA;
         skid_ctrl_q <= '0;
         skid_data_q <= NOP_DATA;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         stall_q     <= stall_d;
      end
   end

endmodule
